// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer: packs the uart_rx byte stream into RGB565/RGB888 pixel
// words for the SDRAM write FIFO, counts pixels per frame, drops partial
// pixels on an inter-byte timeout and flags FIFO overflow.
// Optional build macro: UART_PIXEL_SYNC_EN adds a 0x55,0xAA frame-header hunt
// that gates packing and is re-armed after every frame and every timeout.
module uart_pixel_packer #(
  parameter int unsigned OUT_W       = 24,
  parameter int unsigned H_PIXELS    = 800,
  parameter int unsigned V_LINES     = 480,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             sclk,
  input  logic             s_rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_flag,
  input  logic             fmt_888,
  input  logic             fifo_full,
  input  logic             err_clr,
  output logic             wr_en,
  output logic [OUT_W-1:0] wr_data,
  output logic             frame_done,
  output logic [CNT_W-1:0] pixel_cnt,
  output logic             overflow,
  output logic             timeout_err
);

  localparam int unsigned FRAME_PIX = H_PIXELS * V_LINES;
  localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYC);
  localparam int unsigned PIX_W     = 24;

  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(FRAME_PIX - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [1:0]       byte_idx;
  logic             fmt_lat;
  logic [IDLE_W-1:0] idle_cnt;
  logic [15:0]      asm_q;

  logic             run_c;
  logic             accept_c;
  logic             last_byte_c;
  logic             pix_done_c;
  logic             frame_end_c;
  logic             tmo_c;
  logic [PIX_W-1:0] pix_word_c;

`ifdef UART_PIXEL_SYNC_EN
  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_GOT55 = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;

  // Header-hunt state register
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state_q <= S_HUNT;
    else          state_q <= state_d;
  end

  // Header-hunt next state: 0x55 then 0xAA enters RUN; frame end or timeout re-arms
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HUNT: begin
        if (rx_flag && rx_data == 8'h55) state_d = S_GOT55;
      end
      S_GOT55: begin
        if (rx_flag) begin
          if (rx_data == 8'hAA)      state_d = S_RUN;
          else if (rx_data == 8'h55) state_d = S_GOT55;
          else                       state_d = S_HUNT;
        end
      end
      S_RUN: begin
        if (frame_end_c || tmo_c) state_d = S_HUNT;
      end
      default: state_d = S_HUNT;
    endcase
  end

  assign run_c = (state_q == S_RUN);
`else
  assign run_c = 1'b1;
`endif

  // Pixel completion, frame end and timeout decode
  always_comb begin
    accept_c    = rx_flag & run_c;
    last_byte_c = fmt_lat ? (byte_idx == 2'd2) : (byte_idx == 2'd1);
    pix_done_c  = accept_c & last_byte_c;
    frame_end_c = pix_done_c & (pixel_cnt == LAST_PIX);
    tmo_c       = !rx_flag && (byte_idx != 2'd0) && (idle_cnt == IDLE_LAST);
    pix_word_c  = fmt_lat ? {asm_q, rx_data} : {8'h00, asm_q[7:0], rx_data};
  end

  // Byte assembly, format latch and inter-byte idle timer
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      byte_idx <= 2'd0;
      fmt_lat  <= 1'b0;
      idle_cnt <= '0;
      asm_q    <= '0;
    end else begin
      if (byte_idx == 2'd0 && pixel_cnt == '0) fmt_lat <= fmt_888;

      if (accept_c) begin
        asm_q    <= {asm_q[7:0], rx_data};
        byte_idx <= last_byte_c ? 2'd0 : 2'(byte_idx + 2'd1);
      end else if (tmo_c) begin
        byte_idx <= 2'd0;
      end

      if (rx_flag || byte_idx == 2'd0 || tmo_c) idle_cnt <= '0;
      else                                      idle_cnt <= IDLE_W'(idle_cnt + IDLE_W'(1));
    end
  end

  // Pixel write strobe, data word and frame counter
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      wr_en      <= 1'b0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      pixel_cnt  <= '0;
    end else begin
      wr_en      <= pix_done_c & ~fifo_full;
      frame_done <= frame_end_c;
      if (pix_done_c && !fifo_full) wr_data <= OUT_W'(pix_word_c);
      if (pix_done_c) pixel_cnt <= frame_end_c ? '0 : CNT_W'(pixel_cnt + CNT_W'(1));
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overflow    <= (pix_done_c & fifo_full) | (overflow & ~err_clr);
      timeout_err <= tmo_c | (timeout_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Scoreboard bench for uart_pixel_packer (H_PIXELS=4, V_LINES=2, TIMEOUT_CYC=16).
module tb_uart_pixel_packer;

  localparam int unsigned OUT_W = 24;
  localparam int unsigned CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       rx_data;
  logic             rx_flag;
  logic             fmt_888;
  logic             fifo_full;
  logic             err_clr;
  logic             wr_en;
  logic [OUT_W-1:0] wr_data;
  logic             frame_done;
  logic [CNT_W-1:0] pixel_cnt;
  logic             overflow;
  logic             timeout_err;

  typedef struct packed {
    logic [23:0] d;
    logic        fd;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  uart_pixel_packer #(
    .OUT_W(OUT_W), .H_PIXELS(4), .V_LINES(2), .TIMEOUT_CYC(16), .CNT_W(CNT_W)
  ) dut (
    .sclk(clk), .s_rst_n(rst_n), .rx_data(rx_data), .rx_flag(rx_flag),
    .fmt_888(fmt_888), .fifo_full(fifo_full), .err_clr(err_clr),
    .wr_en(wr_en), .wr_data(wr_data), .frame_done(frame_done),
    .pixel_cnt(pixel_cnt), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One byte strobe; optionally pushes the pixel it completes
  task automatic send(input logic [7:0] b, input bit push, input logic [23:0] d, input bit fd);
    exp_t e;
    @(negedge clk);
    rx_data = b;
    rx_flag = 1'b1;
    if (push) begin
      e.d   = d;
      e.fd  = fd;
      e.cyc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    rx_flag = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Monitor: every wr_en pops and checks data, frame_done and arrival cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wr_en: got data %0h want no write", wr_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_data", 32'(wr_data), 32'(e.d));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
          chk("wr_latency", cyc, e.cyc);
        end
      end else if (frame_done) begin
        total++;
        bad++;
        $display("FAIL lone_frame_done: got frame_done=1 want 0 without wr_en");
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_flag   = 1'b0;
    fmt_888   = 1'b0;
    fifo_full = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_pixel_cnt", 32'(pixel_cnt), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef UART_PIXEL_SYNC_EN
    // Header hunt: noise, repeated 0x55, 0xAA, then one RGB565 pixel
    send(8'h11, 0, 0, 0);
    send(8'h55, 0, 0, 0);
    send(8'h55, 0, 0, 0);
    send(8'hAA, 0, 0, 0);
    send(8'h12, 0, 0, 0);
    send(8'h34, 1, 24'h001234, 0);
    chk("sync_pixel_cnt", 32'(pixel_cnt), 1);
    repeat (3) @(negedge clk);
    // Without a header nothing is packed
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h12, 0, 0, 0);
    send(8'h34, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("nosync_pixel_cnt", 32'(pixel_cnt), 0);
`else
    // RGB565 first pixel
    send(8'h12, 0, 0, 0);
    send(8'h34, 1, 24'h001234, 0);
    chk("t1_pixel_cnt", 32'(pixel_cnt), 1);

    // Mid-frame switch to RGB888 is ignored for this frame
    fmt_888 = 1'b1;

    // Pixel 2 dropped by a full FIFO
    fifo_full = 1'b1;
    send(8'hA1, 0, 0, 0);
    send(8'hA2, 0, 0, 0);
    chk("bp_overflow", 32'(overflow), 1);
    chk("bp_pixel_cnt", 32'(pixel_cnt), 2);
    fifo_full = 1'b0;
    pulse_clr();
    chk("bp_overflow_clr", 32'(overflow), 0);

    // Pixels 3..8 still two bytes each; pixel 8 ends the frame
    for (int i = 3; i <= 8; i++) begin
      send(8'(i), 0, 0, 0);
      send(8'(16 + i), 1, {8'h00, 8'(i), 8'(16 + i)}, (i == 8));
    end
    chk("f1_wrap_pixel_cnt", 32'(pixel_cnt), 0);

    // Full RGB888 frame of bytes 0x00..0x17
    for (int p = 0; p < 8; p++) begin
      send(8'(3 * p), 0, 0, 0);
      send(8'(3 * p + 1), 0, 0, 0);
      send(8'(3 * p + 2), 1, {8'(3 * p), 8'(3 * p + 1), 8'(3 * p + 2)}, (p == 7));
    end
    chk("f2_wrap_pixel_cnt", 32'(pixel_cnt), 0);

    // Timeout discards a lone byte
    fmt_888 = 1'b0;
    send(8'hAB, 0, 0, 0);
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", 32'(timeout_err), 0);
    @(negedge clk);
    chk("tmo_set", 32'(timeout_err), 1);
    chk("tmo_pixel_cnt", 32'(pixel_cnt), 0);
    send(8'h01, 0, 0, 0);
    send(8'h02, 1, 24'h000102, 0);
    chk("tmo_next_cnt", 32'(pixel_cnt), 1);
    pulse_clr();
    chk("tmo_clr", 32'(timeout_err), 0);

    // A byte on the last idle cycle wins over the timeout
    send(8'h10, 0, 0, 0);
    repeat (14) @(negedge clk);
    send(8'h20, 1, 24'h001020, 0);
    repeat (3) @(negedge clk);
    chk("tmo_race_err", 32'(timeout_err), 0);
    chk("tmo_race_cnt", 32'(pixel_cnt), 2);

    // Reset mid-pixel: no write, counters cleared
    send(8'h77, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_pixel_cnt", 32'(pixel_cnt), 0);
    chk("midrst_wr_en", 32'(wr_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h05, 0, 0, 0);
    send(8'h06, 1, 24'h000506, 0);
    chk("postrst_cnt", 32'(pixel_cnt), 1);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_pixel_packer.md
Name: uart_pixel_packer

Overview:
- Assembles the UART byte stream from uart_rx into full pixel words for the SDRAM write FIFO. This replaces the current zero-padded single-byte write.
- Runtime-selectable pixel format: RGB565 (2 bytes/pixel) or RGB888 (3 bytes/pixel).
- Counts pixels per frame and pulses frame_done.
- Recovers from dropped bytes with an inter-byte timeout and reports FIFO overflow.
- Sits between uart_rx and sdram_top wfifo_wr_en/wfifo_wr_data, in the UART clock domain.

Parameters:
- OUT_W, 24: output pixel word width; must be >= 24.
- H_PIXELS, 800: pixels per line.
- V_LINES, 480: lines per frame.
- TIMEOUT_CYC, 50000: idle sclk cycles before a partial pixel is discarded; must be >= 2.
- CNT_W, 20: pixel counter width; must satisfy 2^CNT_W > H_PIXELS*V_LINES.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- s_rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid when rx_flag=1.
- rx_flag  in  1  one-cycle byte-valid strobe.
- fmt_888  in  1  0 = RGB565, 1 = RGB888; sampled only at a frame boundary.
- fifo_full  in  1  write FIFO full.
- err_clr  in  1  clears the sticky error flags.
- wr_en  out  1  one-cycle pixel write strobe.
- wr_data  out  OUT_W  pixel word.
- frame_done  out  1  one-cycle pulse on the last pixel of a frame.
- pixel_cnt  out  CNT_W  pixels accepted in the current frame.
- overflow  out  1  sticky: a pixel was dropped because fifo_full was high.
- timeout_err  out  1  sticky: a partial pixel was discarded on timeout.

Behaviour:
- Reset values: all outputs 0; byte_idx=0; fmt_lat=0; idle counter=0.
- Format latch:
  - fmt_lat <= fmt_888 whenever byte_idx==0 and pixel_cnt==0.
  - fmt_888 changes mid-frame are ignored.
  - nbytes = fmt_lat ? 3 : 2.
- Byte assembly:
  - Bytes arrive MSB first. On rx_flag, the byte is shifted into an assembly register and byte_idx increments.
  - When byte_idx==nbytes-1 and rx_flag=1, the pixel is complete and byte_idx returns to 0.
- Word format:
  - RGB565: wr_data = {zeros, b0, b1}, i.e. the pixel occupies [15:0] and the upper bits are 0.
  - RGB888: wr_data = {zeros, b0, b1, b2}.
- Latency: wr_en asserts exactly 1 cycle after the rx_flag of the final byte. wr_data is valid while wr_en=1 and holds its value otherwise.
- Backpressure:
  - If fifo_full=1 in the cycle wr_en would assert, wr_en stays 0, the pixel is dropped and overflow is set.
  - pixel_cnt still increments so frame alignment is preserved.
- Frame counting:
  - pixel_cnt increments on every completed pixel, whether written or dropped.
  - On the pixel where pixel_cnt == H_PIXELS*V_LINES-1, frame_done pulses together with that pixel's wr_en timing and pixel_cnt wraps to 0.
- Timeout:
  - The idle counter runs only while byte_idx != 0 and clears on rx_flag.
  - At TIMEOUT_CYC-1: byte_idx <= 0, the partial bytes are discarded, timeout_err is set, and pixel_cnt is unchanged.
  - If rx_flag arrives in the same cycle as the timeout, rx_flag wins: the byte is accepted and the counter clears.
- Sticky flags:
  - err_clr=1 clears overflow and timeout_err.
  - If a new error event occurs in the same cycle as err_clr, the set wins.
- Reset mid-frame: everything returns to reset values. No wr_en is issued for a partial pixel.

Optional Feature:
- Macro: UART_PIXEL_SYNC_EN.
- When defined:
  - A state machine HUNT -> GOT55 -> RUN gates pixel assembly.
  - From HUNT, the byte 0x55 moves to GOT55.
  - In GOT55, 0xAA moves to RUN; 0x55 stays in GOT55; any other byte returns to HUNT.
  - Header bytes are never packed.
  - In RUN, behaviour is as above. After frame_done the FSM returns to HUNT.
  - A timeout in RUN returns the FSM to HUNT.
- When undefined: no FSM; packing is always active from reset.

Test Plan (H_PIXELS=4, V_LINES=2, TIMEOUT_CYC=16 unless noted):
1. RGB565: fmt_888=0, bytes 0x12,0x34 -> one wr_en 1 cycle after the 0x34 flag, wr_data=24'h001234, pixel_cnt=1.
2. RGB888 full frame: fmt_888=1, 24 bytes 0x00..0x17 -> 8 wr_en pulses. First word 24'h000102, last word 24'h151617. frame_done coincides with the 8th wr_en; pixel_cnt returns to 0.
3. Mid-frame format change: fmt_888 toggled 0 -> 1 after the 1st pixel -> the frame stays 2 bytes/pixel; 3-byte packing starts on the next frame.
4. Backpressure: fifo_full=1 during the 2nd pixel -> no wr_en for that pixel, overflow=1, pixel_cnt=2. err_clr pulse -> overflow=0.
5. Timeout: byte 0xAB, then 16 idle cycles -> timeout_err=1 and byte_idx reset. Next bytes 0x01,0x02 -> wr_data=24'h000102. Separately, rx_flag at idle cycle 15 -> no timeout.
6. Sync (UART_PIXEL_SYNC_EN defined): bytes 0x11,0x55,0x55,0xAA,0x12,0x34 -> exactly one wr_en, wr_data=24'h001234. After reset, 0x12,0x34 without a header -> no wr_en.
